exe_stage: RTL

- Execute stage of the 5-stage pipeline. It sits between the ID/EXE pipeline register and the EXE/MEM pipeline register.
- Resolves operand forwarding from the MEM and WB stages and performs single-cycle ALU operations.
- Runs a 32-iteration multi-cycle multiply/divide unit that stalls the front end while busy.
- Produces the ALU result, the forwarded store value and the control bits for EXE/MEM.

---
 rtl/exe_stage_pkg.sv | 33 +++
 rtl/exe_stage_muldiv.sv | 89 ++++++++
 rtl/exe_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: datapath width, EXE_CMD codes and
// the mul/div sequencer state encoding.
package exe_stage_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_NOP0 = 4'b0001;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MULU = 4'b1100;
  localparam logic [3:0] CMD_DIVU = 4'b1101;
  localparam logic [3:0] CMD_REMU = 4'b1110;
  localparam logic [3:0] CMD_NOP1 = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] cmd);
    return (cmd == CMD_MULU) || (cmd == CMD_DIVU) || (cmd == CMD_REMU);
  endfunction

endpackage

// File: rtl/exe_stage_muldiv.sv
// Iterative unsigned multiply / divide: one shift-add or restoring-subtract
// step per cycle, result held for the single DONE cycle.
module muldiv_unit
  import exe_stage_pkg::*;
#(
  parameter int XLEN    = exe_stage_pkg::XLEN,
  parameter int MD_ITER = exe_stage_pkg::MD_ITER
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [3:0]      cmd_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(MD_ITER);

  md_state_e       state_q;
  logic [CW-1:0]   count_q;
  logic [3:0]      cmd_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] acc_q;

  // a_q holds multiplicand or divisor, b_q multiplier or dividend/quotient,
  // acc_q the partial product or partial remainder.
  logic [XLEN:0]   trial;
  logic            fits;
  logic [XLEN-1:0] diff;

  assign trial = {acc_q, b_q[XLEN-1]};
  assign fits  = trial >= {1'b0, a_q};
  assign diff  = trial[XLEN-1:0] - a_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_i) begin
            cmd_q   <= cmd_i;
            count_q <= CW'(MD_ITER - 1);
            acc_q   <= '0;
            a_q     <= (cmd_i == CMD_MULU) ? op1_i : op2_i;
            b_q     <= (cmd_i == CMD_MULU) ? op2_i : op1_i;
            state_q <= MD_RUN;
          end
        end
        MD_RUN: begin
          if (cmd_q == CMD_MULU) begin
            acc_q <= acc_q + (b_q[0] ? a_q : '0);
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= fits ? diff : trial[XLEN-1:0];
            b_q   <= {b_q[XLEN-2:0], fits};
          end
          count_q <= count_q - 1'b1;
          if (count_q == '0) state_q <= MD_DONE;
        end
        MD_DONE: state_q <= MD_IDLE;
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  always_comb begin
    case (cmd_q)
      CMD_MULU: result_o = acc_q;
      CMD_DIVU: result_o = b_q;
      CMD_REMU: result_o = acc_q;
      default:  result_o = '0;
    endcase
  end

  assign busy_o = ((state_q == MD_IDLE) && start_i) || (state_q == MD_RUN);
  assign done_o = (state_q == MD_DONE);

endmodule

// File: rtl/exe_stage.sv
// Execute stage: MEM/WB operand forwarding, single-cycle ALU and a stalling
// iterative mul/div unit feeding the EXE/MEM register.
module exe_stage #(
  parameter int XLEN    = exe_stage_pkg::XLEN,
  parameter int MD_ITER = exe_stage_pkg::MD_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      EXE_CMD,
  input  logic [XLEN-1:0] val1,
  input  logic [XLEN-1:0] val2,
  input  logic            imm_sel,
  input  logic [XLEN-1:0] ST_value,
  input  logic [4:0]      src1,
  input  logic [4:0]      src2,
  input  logic [4:0]      dest,
  input  logic            WB_EN,
  input  logic            MEM_R_EN,
  input  logic            MEM_W_EN,
  input  logic [4:0]      mem_dest,
  input  logic            mem_wb_en,
  input  logic [XLEN-1:0] mem_value,
  input  logic [4:0]      wb_dest,
  input  logic            wb_wb_en,
  input  logic [XLEN-1:0] wb_value,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] st_value_out,
  output logic [4:0]      dest_out,
  output logic            WB_EN_out,
  output logic            MEM_R_EN_out,
  output logic            MEM_W_EN_out,
  output logic            stall
);
  import exe_stage_pkg::*;

  logic [XLEN-1:0] op1, op2, src2Fwd, stFwd, aluRes, mdResult;
  logic            isMd, mdBusy, mdDone;

  // MEM wins over WB; register 0 is never forwarded.
  always_comb begin
    op1 = val1;
    if (mem_wb_en && mem_dest == src1 && src1 != 5'd0)     op1 = mem_value;
    else if (wb_wb_en && wb_dest == src1 && src1 != 5'd0)  op1 = wb_value;

    src2Fwd = val2;
    stFwd   = ST_value;
    if (mem_wb_en && mem_dest == src2 && src2 != 5'd0) begin
      src2Fwd = mem_value;
      stFwd   = mem_value;
    end else if (wb_wb_en && wb_dest == src2 && src2 != 5'd0) begin
      src2Fwd = wb_value;
      stFwd   = wb_value;
    end
    op2 = imm_sel ? val2 : src2Fwd;
  end

  always_comb begin
    case (EXE_CMD)
      CMD_ADD: aluRes = op1 + op2;
      CMD_SUB: aluRes = op1 - op2;
      CMD_AND: aluRes = op1 & op2;
      CMD_OR:  aluRes = op1 | op2;
      CMD_NOR: aluRes = ~(op1 | op2);
      CMD_XOR: aluRes = op1 ^ op2;
      CMD_SLL: aluRes = op1 << op2[4:0];
      CMD_SRA: aluRes = $signed(op1) >>> op2[4:0];
      CMD_SRL: aluRes = op1 >> op2[4:0];
      default: aluRes = '0;
    endcase
  end

  assign isMd = is_muldiv(EXE_CMD);

  muldiv_unit #(.XLEN(XLEN), .MD_ITER(MD_ITER)) u_muldiv (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (isMd),
    .cmd_i    (EXE_CMD),
    .op1_i    (op1),
    .op2_i    (op2),
    .busy_o   (mdBusy),
    .done_o   (mdDone),
    .result_o (mdResult)
  );

  // While the unit is busy the stage emits a bubble to EXE/MEM.
  assign stall        = mdBusy;
  assign alu_result   = isMd ? (mdDone ? mdResult : '0) : aluRes;
  assign st_value_out = stFwd;
  assign dest_out     = dest;
  assign WB_EN_out    = WB_EN    & ~mdBusy;
  assign MEM_R_EN_out = MEM_R_EN & ~mdBusy;
  assign MEM_W_EN_out = MEM_W_EN & ~mdBusy;

endmodule
